// File: rtl/l2_pkg.sv
// Shared defaults and lane-entry layout for the L2 tile response block.
package l2_pkg;
  localparam int TILES_DEF  = 4;
  localparam int CLID_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int LAT_DEF    = 8;

  // Fields are sized for the widest legal configuration (clid up to 16 bits, LAT up to 255).
  localparam int CLID_W_MAX = 16;
  localparam int CNT_W_MAX  = 8;

  typedef struct packed {
    logic [CLID_W_MAX-1:0] clid;
    logic [CNT_W_MAX-1:0]  cnt;
  } l2_entry_t;
endpackage

// File: rtl/l2_tile_rsp_lane.sv
// One tile lane: an in-order queue whose entries mature LAT cycles after acceptance.
// Optional pop counter enabled by L2_TILE_RSP_PERF_EN.
module l2_tile_rsp_lane
  import l2_pkg::*;
#(
  parameter int clid_width = CLID_W_DEF,
  parameter int depth      = DEPTH_DEF,
  parameter int LAT        = LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_v,
  output logic                  req_r,
  input  logic [clid_width-1:0] req_clid,
  output logic                  rsp_v,
  input  logic                  rsp_r,
  output logic [clid_width-1:0] rsp_clid
`ifdef L2_TILE_RSP_PERF_EN
  ,
  output logic [15:0]           rsp_cnt
`endif
);
  localparam int AW = $clog2(depth);
  localparam logic [CNT_W_MAX-1:0] CNT_LOAD = CNT_W_MAX'(LAT - 1);

  l2_entry_t       entry_q [depth];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  l2_entry_t       head;
  logic            push;
  logic            pop;

  assign head     = entry_q[rd_ptr_q];
  // Ready depends only on stored occupancy, so a pop never frees a slot in the same cycle.
  assign req_r    = (count_q < (AW+1)'(depth));
  assign rsp_v    = (count_q != '0) && (head.cnt == '0);
  assign rsp_clid = rsp_v ? head.clid[clid_width-1:0] : '0;
  assign push     = req_v && req_r;
  assign pop      = rsp_v && rsp_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < depth; k++) entry_q[k] <= '0;
    end else begin
      for (int k = 0; k < depth; k++) begin
        if (entry_q[k].cnt != '0) entry_q[k].cnt <= entry_q[k].cnt - CNT_W_MAX'(1);
      end
      if (push) begin
        entry_q[wr_ptr_q].clid <= CLID_W_MAX'(req_clid);
        entry_q[wr_ptr_q].cnt  <= CNT_LOAD;
        wr_ptr_q               <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

`ifdef L2_TILE_RSP_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rsp_cnt <= '0;
    else if (pop) rsp_cnt <= rsp_cnt + 16'd1;
  end
`endif
endmodule

// File: rtl/l2_tile_rsp.sv
// Per-tile fixed-latency response return: TILES independent lanes, no shared state.
// Per-tile response counters are compiled in with L2_TILE_RSP_PERF_EN.
module l2_tile_rsp
  import l2_pkg::*;
#(
  parameter int TILES      = TILES_DEF,
  parameter int clid_width = CLID_W_DEF,
  parameter int depth      = DEPTH_DEF,
  parameter int LAT        = LAT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [TILES-1:0]            i_tile_req_v,
  output logic [TILES-1:0]            i_tile_req_r,
  input  logic [TILES*clid_width-1:0] i_tile_req_clid,
  output logic [TILES-1:0]            o_tile_rsp_v,
  input  logic [TILES-1:0]            o_tile_rsp_r,
  output logic [TILES*clid_width-1:0] o_tile_rsp_clid
`ifdef L2_TILE_RSP_PERF_EN
  ,
  output logic [TILES*16-1:0]         o_rsp_cnt
`endif
);
  for (genvar i = 0; i < TILES; i++) begin : g_lane
    l2_tile_rsp_lane #(
      .clid_width (clid_width),
      .depth      (depth),
      .LAT        (LAT)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .req_v    (i_tile_req_v[i]),
      .req_r    (i_tile_req_r[i]),
      .req_clid (i_tile_req_clid[i*clid_width +: clid_width]),
      .rsp_v    (o_tile_rsp_v[i]),
      .rsp_r    (o_tile_rsp_r[i]),
      .rsp_clid (o_tile_rsp_clid[i*clid_width +: clid_width])
`ifdef L2_TILE_RSP_PERF_EN
      ,
      .rsp_cnt  (o_rsp_cnt[i*16 +: 16])
`endif
    );
  end
endmodule

// File: tb/tb_l2_tile_rsp.sv
// Randomized scoreboard bench for l2_tile_rsp with directed corner scenarios.
module tb_l2_tile_rsp;
  localparam int TILES = 4;
  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [TILES-1:0]      req_v;
  logic [TILES-1:0]      req_r;
  logic [TILES*CW-1:0]   req_clid;
  logic [TILES-1:0]      rsp_v;
  logic [TILES-1:0]      rsp_r;
  logic [TILES*CW-1:0]   rsp_clid;
`ifdef L2_TILE_RSP_PERF_EN
  logic [TILES*16-1:0]   rsp_cnt;
  int                    pops [TILES];
`endif

  l2_tile_rsp #(.TILES(TILES), .clid_width(CW), .depth(DEPTH), .LAT(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_tile_req_v    (req_v),
    .i_tile_req_r    (req_r),
    .i_tile_req_clid (req_clid),
    .o_tile_rsp_v    (rsp_v),
    .o_tile_rsp_r    (rsp_r),
    .o_tile_rsp_clid (rsp_clid)
`ifdef L2_TILE_RSP_PERF_EN
    ,
    .o_rsp_cnt       (rsp_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: per tile, an ordered list of outstanding requests and the cycle each matures.
  typedef struct {
    int clid;
    int due;
  } exp_t;

  exp_t sb [TILES][$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s tile%0d cyc=%0d got=%0d want=%0d", nm, t, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs to the model mid-cycle, then applies the upcoming edge's handshakes.
  always @(negedge clk) begin
    int exp_r;
    int exp_v;
    if (!reset) begin
      for (int i = 0; i < TILES; i++) begin
        sb[i].delete();
`ifdef L2_TILE_RSP_PERF_EN
        pops[i] = 0;
`endif
        chk("rst_rsp_v", i, int'(rsp_v[i]), 0);
        chk("rst_rsp_clid", i, int'(rsp_clid[i*CW +: CW]), 0);
        chk("rst_req_r", i, int'(req_r[i]), 1);
      end
    end else begin
      for (int i = 0; i < TILES; i++) begin
        exp_r = (sb[i].size() < DEPTH) ? 1 : 0;
        exp_v = (sb[i].size() > 0 && cyc >= sb[i][0].due) ? 1 : 0;
        chk("req_r", i, int'(req_r[i]), exp_r);
        chk("rsp_v", i, int'(rsp_v[i]), exp_v);
        if (exp_v == 1 && rsp_v[i]) chk("rsp_clid", i, int'(rsp_clid[i*CW +: CW]), sb[i][0].clid);
        if (exp_v == 1 && rsp_r[i]) begin
          void'(sb[i].pop_front());
`ifdef L2_TILE_RSP_PERF_EN
          pops[i] = (pops[i] + 1) % 65536;
`endif
        end
        // Accepted at the next edge (cycle cyc+1); valid after edge cyc+1+LAT-1.
        if (req_v[i] && exp_r == 1) sb[i].push_back('{int'(req_clid[i*CW +: CW]), cyc + LAT});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int t, input logic v, input int clid);
    req_v[t] = v;
    req_clid[t*CW +: CW] = CW'(clid);
  endtask

`ifdef L2_TILE_RSP_PERF_EN
  task automatic perf_check(input string nm);
    for (int i = 0; i < TILES; i++) chk(nm, i, int'(rsp_cnt[i*16 +: 16]), pops[i]);
  endtask
`endif

  initial begin
    req_v = '0;
    req_clid = '0;
    rsp_r = '1;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);

    // Single request on tile 0.
    set_req(0, 1'b1, 5);
    step();
    req_v = '0;
    step(12);

    // Tile 2 burst of four with response stalled, then released.
    rsp_r[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_req(2, 1'b1, k);
      step();
    end
    req_v = '0;
    step(12);
    rsp_r[2] = 1'b1;
    step(8);

    // Tile 1 full, push held while the head pops.
    rsp_r[1] = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      set_req(1, 1'b1, k);
      step();
    end
    set_req(1, 1'b1, 10);
    step(10);
    rsp_r[1] = 1'b1;
    step(3);
    req_v = '0;
    step(15);

    // All tiles at once.
    for (int t = 0; t < TILES; t++) set_req(t, 1'b1, 15 - t);
    step();
    req_v = '0;
    step(12);

    // Reset while tile 1 holds three outstanding entries.
    rsp_r[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 3 + k);
      step();
    end
    req_v = '0;
    step(3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    rsp_r = '1;
    step(20);

    // Ten responses on tile 3 only.
    for (int k = 0; k < 10; k++) begin
      set_req(3, 1'b1, int'($urandom_range(15, 0)));
      step();
    end
    req_v = '0;
    step(20);
`ifdef L2_TILE_RSP_PERF_EN
    perf_check("perf_tile3");
`endif

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 1500; k++) begin
      for (int t = 0; t < TILES; t++) begin
        set_req(t, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)));
        rsp_r[t] = ($urandom_range(3, 0) != 0);
      end
      step();
    end

    // Drain and confirm nothing is left outstanding.
    req_v = '0;
    rsp_r = '1;
    step(40);
    for (int t = 0; t < TILES; t++) chk("drain_empty", t, sb[t].size(), 0);
`ifdef L2_TILE_RSP_PERF_EN
    perf_check("perf_final");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
